// File: rtl/udp_fifo_payload_reader.sv
// Read-side consumer of the FWFT prefetch FIFO: packs bytes into fixed-length UDP payloads, padding on starvation.
// Optional running payload checksum is enabled by defining UDP_FIFO_RD_CSUM_EN.
module udp_fifo_payload_reader #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   LEN_W    = 12,
  parameter int unsigned   TIMEOUT  = 1024,
  parameter logic [DW-1:0] PAD_BYTE = '0
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DW-1:0]    fifo_rd_data,
  input  logic             fifo_rd_vld,
  output logic             fifo_rd_en,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             pkt_req,
  input  logic             pkt_ack,
  output logic [DW-1:0]    tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      pad_cnt
`ifdef UDP_FIFO_RD_CSUM_EN
  ,
  output logic [15:0]      csum,
  output logic             csum_vld
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_PAD,
    S_DRAIN
  } state_e;

  localparam logic [15:0]      STARVE_LAST = 16'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] REM_ONE     = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      starve_q, starve_d;
  logic [DW-1:0]    tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_last_q, tx_last_d;
  logic             pkt_req_q, pkt_req_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      pad_cnt_q, pad_cnt_d;

  logic free;
  logic last_rem;

  // The output register can take a new beat when it is empty or being accepted.
  assign free     = ~tx_valid_q | tx_ready;
  assign last_rem = (rem_q == REM_ONE);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    starve_d   = starve_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    pkt_req_d  = pkt_req_q;
    pkt_cnt_d  = pkt_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    fifo_rd_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_rd_vld && (pkt_len != '0)) begin
          rem_d     = pkt_len;
          pkt_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (pkt_ack) begin
          pkt_req_d = 1'b0;
          starve_d  = '0;
          state_d   = S_STREAM;
        end
      end

      S_STREAM: begin
        fifo_rd_en = fifo_rd_vld & free & (rem_q != '0);
        if (fifo_rd_en) begin
          tx_data_d  = fifo_rd_data;
          tx_valid_d = 1'b1;
          tx_last_d  = last_rem;
          rem_d      = rem_q - REM_ONE;
          starve_d   = '0;
          if (last_rem) begin
            state_d = S_DRAIN;
          end
        end else if (free) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          if (!fifo_rd_vld) begin
            starve_d = starve_q + 16'd1;
            if (starve_q == STARVE_LAST) begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        // Fill to length without touching the FIFO; late data is left for the next packet.
        if (free) begin
          tx_data_d  = PAD_BYTE;
          tx_valid_d = 1'b1;
          tx_last_d  = last_rem;
          rem_d      = rem_q - REM_ONE;
          if (pad_cnt_q != 16'hFFFF) begin
            pad_cnt_d = pad_cnt_q + 16'd1;
          end
          if (last_rem) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      starve_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      pkt_req_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      pad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      starve_q   <= starve_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      pkt_req_q  <= pkt_req_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign pkt_req  = pkt_req_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign pad_cnt  = pad_cnt_q;
  assign busy     = (state_q != S_IDLE);

`ifdef UDP_FIFO_RD_CSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] csum_q, csum_d;
  logic        csum_vld_q, csum_vld_d;
  logic        lo_q, lo_d;
  logic [16:0] sum_add;
  logic        load;
  logic        drain_hs;

  assign load     = ((state_q == S_STREAM) && fifo_rd_en) || ((state_q == S_PAD) && free);
  assign drain_hs = (state_q == S_DRAIN) && tx_valid_q && tx_ready;

  // Bytes alternate high/low within big-endian 16-bit words; carries wrap around.
  always_comb begin
    sum_d      = sum_q;
    lo_d       = lo_q;
    csum_d     = csum_q;
    csum_vld_d = 1'b0;
    sum_add    = '0;
    if ((state_q == S_REQ) && pkt_ack) begin
      sum_d = '0;
      lo_d  = 1'b0;
    end else if (load) begin
      sum_add = {1'b0, sum_q} + (lo_q ? {9'b0, tx_data_d[7:0]} : {1'b0, tx_data_d[7:0], 8'h00});
      sum_d   = sum_add[15:0] + {15'b0, sum_add[16]};
      lo_d    = ~lo_q;
    end
    if (drain_hs) begin
      csum_d     = ~sum_q;
      csum_vld_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      sum_q      <= '0;
      lo_q       <= 1'b0;
      csum_q     <= '0;
      csum_vld_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      lo_q       <= lo_d;
      csum_q     <= csum_d;
      csum_vld_q <= csum_vld_d;
    end
  end

  assign csum     = csum_q;
  assign csum_vld = csum_vld_q;
`endif

endmodule

// File: tb/tb_udp_fifo_payload_reader.sv
// Directed bench for udp_fifo_payload_reader: a FIFO model, an expected-beat queue and literal spot checks.
module tb_udp_fifo_payload_reader;

  localparam int          TIMEOUT = 8;
  localparam logic [7:0]  PAD     = 8'h00;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_vld;
  logic        fifo_rd_en;
  logic [11:0] pkt_len = '0;
  logic        pkt_req;
  logic        pkt_ack = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [15:0] pad_cnt;
`ifdef UDP_FIFO_RD_CSUM_EN
  logic [15:0] csum;
  logic        csum_vld;
  logic [15:0] csum_seen = '0;
  int          csum_vld_n = 0;
`endif

  udp_fifo_payload_reader #(
    .DW(8), .LEN_W(12), .TIMEOUT(TIMEOUT), .PAD_BYTE(PAD)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
    .pkt_len(pkt_len), .pkt_req(pkt_req), .pkt_ack(pkt_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .pkt_cnt(pkt_cnt), .pad_cnt(pad_cnt)
`ifdef UDP_FIFO_RD_CSUM_EN
    , .csum(csum), .csum_vld(csum_vld)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         pad;
  } beat_t;

  int checks = 0;
  int failures = 0;

  // FIFO model: stimulus owns wr_ptr, the clocked process owns rd_ptr; reset flushes it.
  logic [7:0] fifo_mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  int         pop_cnt = 0;
  bit         pop_n = 1'b0;
  assign fifo_rd_vld  = (wr_ptr != rd_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr];

  beat_t       exp_q[$];
  logic [7:0]  hs_data[$];
  bit          hs_last[$];
  int          hs_cyc[$];
  int          hs_count = 0;
  int          cyc = 0;
  logic [15:0] model_pkt = '0;
  logic [15:0] model_pad = '0;
  bit          stall_q = 1'b0;
  logic [7:0]  stall_data = '0;
  bit          stall_last = 1'b0;
  beat_t       cur;
  bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fifo(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = b[i];
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  // Expected payload: the first n available bytes, then PAD up to len, last flag on the final beat.
  task automatic plan_exp(input logic [7:0] b [8], input int n, input int len);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = (i < n) ? b[i] : PAD;
      e.last = (i == len - 1);
      e.pad  = (i >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_last.delete();
    hs_cyc.delete();
  endtask

  always @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_ptr <= wr_ptr;
    end else if (pop_n) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Compare process: sampled mid-cycle, a handshake here is accepted at the following edge.
  always @(negedge rd_clk) begin
    cyc++;
    pop_n = fifo_rd_en;
    if (rd_rst) begin
      exp_q.delete();
      model_pkt = '0;
      model_pad = '0;
      stall_q   = 1'b0;
    end else begin
      check("pkt_cnt", pkt_cnt, model_pkt);
      check("rd_en_qual", fifo_rd_en & ~fifo_rd_vld, 0);
      if (stall_q) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
        check("stall_last", tx_last, stall_last);
      end
      if (tx_valid && tx_ready) begin
        hs_count++;
        hs_data.push_back(tx_data);
        hs_last.push_back(tx_last);
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", tx_data, $time);
        end else begin
          cur = exp_q.pop_front();
          check("beat_data", tx_data, cur.data);
          check("beat_last", tx_last, cur.last);
          if (cur.last) model_pkt = model_pkt + 16'd1;
          if (cur.pad)  model_pad = model_pad + 16'd1;
        end
      end
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_last = tx_last;
`ifdef UDP_FIFO_RD_CSUM_EN
      if (csum_vld) begin
        csum_vld_n++;
        csum_seen = csum;
      end
`endif
    end
  end

  // One packet: grant after ack_delay cycles of pkt_req, optional backpressure, optional byte pushed during padding.
  task automatic run_pkt(input int ack_delay, input bit bp, input bit late);
    int i = 0;
    int req_cycles = 0;
    bit acked = 1'b0;
    bit ack_prev = 1'b0;
    bit late_done = 1'b0;
    logic [7:0] lb [8] = '{8'h5A, 0, 0, 0, 0, 0, 0, 0};
    while (i < 400) begin
      tx_ready = bp ? bp_pat[i % 4] : 1'b1;
      pkt_ack  = 1'b0;
      if (ack_prev) check("req_drop", pkt_req, 0);
      ack_prev = 1'b0;
      if (!acked && req_cycles > 0) check("req_hold", pkt_req, 1);
      if (!acked && (pkt_req || req_cycles > 0)) begin
        if (req_cycles == ack_delay) begin
          pkt_ack  = 1'b1;
          acked    = 1'b1;
          ack_prev = 1'b1;
          pkt_len  = '0;
        end
        req_cycles++;
      end
      if (late && !late_done && model_pad >= 16'd1) begin
        push_fifo(lb, 1);
        late_done = 1'b1;
      end
      @(posedge rd_clk); #1;
      i++;
      if (acked && !ack_prev && !busy && exp_q.size() == 0) break;
    end
    pkt_ack  = 1'b0;
    tx_ready = 1'b1;
    if (i >= 400) begin
      checks++;
      failures++;
      $display("FAIL pkt_timeout: got busy=%0b pending=%0d expected packet done", busy, exp_q.size());
    end
  endtask

  initial begin
    int base;
    int pop_base;
    int i;
    bit acked;

    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    @(posedge rd_clk); #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pkt_req", pkt_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_pad_cnt", pad_cnt, 0);

    // Basic packet.
    clear_log();
    push_fifo('{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 4);
    plan_exp('{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 4, 4);
    pkt_len = 12'd4;
    run_pkt(3, 1'b0, 1'b0);
    check("basic_beats", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      check("basic_b0", hs_data[0], 8'h11);
      check("basic_b3", hs_data[3], 8'h44);
      check("basic_last2", hs_last[2], 0);
      check("basic_last3", hs_last[3], 1);
      check("basic_back2back", hs_cyc[3] - hs_cyc[0], 3);
    end
    check("basic_pkt_cnt", pkt_cnt, 1);
    check("basic_fifo_empty", fifo_rd_vld, 0);

    // Backpressure.
    clear_log();
    pop_base = pop_cnt;
    push_fifo('{8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0, 0}, 3);
    plan_exp('{8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0, 0}, 3, 3);
    pkt_len = 12'd3;
    run_pkt(1, 1'b1, 1'b0);
    check("bp_pops", pop_cnt - pop_base, 3);
    check("bp_beats", hs_data.size(), 3);
    if (hs_data.size() == 3) check("bp_b1", hs_data[1], 8'hBB);
    check("bp_pkt_cnt", pkt_cnt, 2);
    check("bp_fifo_empty", fifo_rd_vld, 0);

    // Starvation then padding; a byte arriving during padding must stay queued.
    clear_log();
    push_fifo('{8'h01, 8'h02, 0, 0, 0, 0, 0, 0}, 2);
    plan_exp('{8'h01, 8'h02, 0, 0, 0, 0, 0, 0}, 2, 5);
    pkt_len = 12'd5;
    run_pkt(0, 1'b0, 1'b1);
    check("starve_beats", hs_data.size(), 5);
    if (hs_data.size() == 5) begin
      check("starve_pad0", hs_data[2], 8'h00);
      check("starve_pad_gap", hs_cyc[2] - hs_cyc[1], TIMEOUT + 1);
      check("starve_last3", hs_last[3], 0);
      check("starve_last4", hs_last[4], 1);
    end
    check("starve_pad_cnt", pad_cnt, 3);
    check("starve_pad_model", pad_cnt, model_pad);
    check("starve_pkt_cnt", pkt_cnt, 3);
    check("starve_late_kept", fifo_rd_vld, 1);
    check("starve_late_data", fifo_rd_data, 8'h5A);

    // Zero length with data waiting, plus a stray grant in IDLE.
    pkt_len = '0;
    for (int k = 0; k < 100; k++) begin
      pkt_ack = (k == 50);
      @(posedge rd_clk); #1;
      check("zero_req", pkt_req, 0);
      check("zero_busy", busy, 0);
    end
    pkt_ack = 1'b0;
    check("zero_pkt_cnt", pkt_cnt, 3);
    check("zero_fifo_kept", fifo_rd_vld, 1);

    // Reset after the second beat of a 6-byte packet.
    push_fifo('{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 0, 0, 0}, 5);
    plan_exp('{8'h5A, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 0, 0}, 6, 6);
    pkt_len = 12'd6;
    base = hs_count;
    i = 0;
    acked = 1'b0;
    while (i < 200 && hs_count < base + 2) begin
      pkt_ack = 1'b0;
      if (!acked && pkt_req) begin
        pkt_ack = 1'b1;
        acked   = 1'b1;
        pkt_len = '0;
      end
      @(posedge rd_clk); #1;
      i++;
    end
    pkt_ack = 1'b0;
    if (i >= 200) begin
      checks++;
      failures++;
      $display("FAIL rst_wait: got %0d beats expected 2", hs_count - base);
    end
    rd_rst = 1'b1;
    @(posedge rd_clk); #1;
    rd_rst = 1'b0;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_pkt_req", pkt_req, 0);

    // Single-byte packet after reset.
    clear_log();
    push_fifo('{8'h9C, 0, 0, 0, 0, 0, 0, 0}, 1);
    plan_exp('{8'h9C, 0, 0, 0, 0, 0, 0, 0}, 1, 1);
    pkt_len = 12'd1;
    run_pkt(2, 1'b0, 1'b0);
    check("one_beats", hs_data.size(), 1);
    if (hs_data.size() == 1) begin
      check("one_data", hs_data[0], 8'h9C);
      check("one_last", hs_last[0], 1);
    end
    check("one_pkt_cnt", pkt_cnt, 1);
    check("one_pad_cnt", pad_cnt, 0);

`ifdef UDP_FIFO_RD_CSUM_EN
    csum_vld_n = 0;
    push_fifo('{8'h45, 8'h00, 8'h00, 8'h1C, 0, 0, 0, 0}, 4);
    plan_exp('{8'h45, 8'h00, 8'h00, 8'h1C, 0, 0, 0, 0}, 4, 4);
    pkt_len = 12'd4;
    run_pkt(1, 1'b0, 1'b0);
    repeat (3) @(posedge rd_clk);
    #1;
    check("csum_value", csum_seen, 16'hBAE3);
    check("csum_vld_once", csum_vld_n, 1);
`endif

    repeat (2) @(posedge rd_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_fifo_payload_reader.md
Name: udp_fifo_payload_reader

Overview:
- Read-side consumer of the async prefetch FIFO (FWFT, rd_vld/rd_en handshake) in the udp_osd path.
- Drains bytes into fixed-length UDP payload packets: requests a packet slot from the UDP TX stack, streams exactly pkt_len bytes through a registered valid/ready output, and asserts tx_last on the final byte.
- If the FIFO starves mid-packet it pads to length after a timeout, so the UDP length field always stays correct.

Parameters:
- DW, 8, data width of the FIFO read port and tx_data.
- LEN_W, 12, width of pkt_len and the remaining-byte counter.
- TIMEOUT, 1024, starve cycles before padding starts (legal 2..65535).
- PAD_BYTE, 8'h00, fill value used for padded beats.

Ports:
- rd_clk  in  1  single clock (FIFO read clock).
- rd_rst  in  1  synchronous, active-high reset.
- fifo_rd_data  in  DW  FIFO head data, valid when fifo_rd_vld=1.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  1  pop strobe to FIFO; combinational.
- pkt_len  in  LEN_W  payload length in bytes; sampled on IDLE->REQ.
- pkt_req  out  1  packet slot request to UDP TX.
- pkt_ack  in  1  single-cycle grant; header is sent, payload may start.
- tx_data  out  DW  payload byte, registered.
- tx_valid  out  1  payload valid, registered.
- tx_ready  in  1  UDP TX accepts the beat.
- tx_last  out  1  final byte of the packet, registered, qualified by tx_valid.
- busy  out  1  state != IDLE.
- pkt_cnt  out  16  completed packets, wraps at 16'hFFFF->0.
- pad_cnt  out  16  total padded bytes, saturates at 16'hFFFF.

Behaviour:
- Interface: one clock rd_clk; rd_rst is synchronous, active-high.
- Reset (synchronous, active-high): state=IDLE, tx_valid=0, tx_last=0, tx_data=0, pkt_req=0, pkt_cnt=0, pad_cnt=0, counters=0.
- Reset mid-packet: the packet is abandoned, with no tx_last and no padding.
- Output slot free: free = ~tx_valid | tx_ready.
- FSM states: IDLE, REQ, STREAM, PAD, DRAIN.
- IDLE:
  - If fifo_rd_vld=1 and pkt_len!=0: latch rem=pkt_len, go to REQ.
  - If pkt_len==0: stay in IDLE and never request.
- REQ:
  - pkt_req=1 (registered, set on entry).
  - On pkt_ack: pkt_req=0 next cycle, go to STREAM.
  - pkt_ack seen in any other state is ignored.
- STREAM:
  - fifo_rd_en = fifo_rd_vld & free & (rem!=0).
  - On pop: tx_data<=fifo_rd_data, tx_valid<=1, rem<=rem-1, tx_last<=(rem==1), starve<=0.
  - Latency FIFO pop -> tx_valid is 1 cycle. Full throughput: 1 byte/cycle while tx_ready=1 and FIFO non-empty.
  - If free=1 and fifo_rd_vld=0: starve++. No beat loaded; tx_valid<=0 if the current beat is accepted.
  - Pop with rem==1: go to DRAIN.
  - starve==TIMEOUT-1 with no pop that cycle: go to PAD.
- PAD:
  - fifo_rd_en=0.
  - Each free cycle loads PAD_BYTE: rem--, pad_cnt++.
  - tx_last on the rem==1 beat, then DRAIN.
  - FIFO data arriving during PAD stays in the FIFO for the next packet.
- DRAIN:
  - fifo_rd_en=0.
  - When tx_valid&tx_ready: tx_valid<=0, tx_last<=0, pkt_cnt++, go to IDLE.
- Backpressure: tx_valid=1 & tx_ready=0 holds tx_data/tx_last stable and blocks pops. starve does not count while free=0.
- Counter widths: rem is LEN_W unsigned. pkt_len=2^LEN_W-1 is legal. rem never underflows.
- Cannot occur by construction: fifo_rd_en=1 while fifo_rd_vld=0.

Optional Feature:
- Macro: UDP_FIFO_RD_CSUM_EN.
- Defined:
  - Adds outputs csum[15:0] and csum_vld.
  - csum is a running 16-bit one's-complement sum of payload bytes, padding included, taken as big-endian 16-bit words; an odd trailing byte is the high byte.
  - Cleared on REQ->STREAM.
  - In the DRAIN handshake cycle: csum<=~sum, csum_vld=1 for exactly one cycle.
- Undefined: no ports, no logic.

Test Plan:
- Basic packet: pkt_len=4; FIFO holds 8'h11,22,33,44; ack after 3 cycles; tx_ready=1 → pkt_req high until ack; 4 consecutive beats 11..44; tx_last only on 44; pkt_cnt=1; FIFO empty.
- Backpressure: pkt_len=3; tx_ready toggles 1,0,0,1,... → no byte lost or duplicated; tx_data stable while stalled; exactly 3 pops.
- Starvation: TIMEOUT=8, pkt_len=5; FIFO supplies 2 bytes then nothing → after 8 starve cycles 3 beats of 8'h00; tx_last on the 5th beat; pad_cnt=3.
- Zero length / ack outside REQ: pkt_len=0 with FIFO non-empty → pkt_req stays 0 for 100 cycles; a stray pkt_ack in IDLE → no effect.
- Reset mid-STREAM: rd_rst for 1 cycle after byte 2 of 6 → next cycle tx_valid=0, busy=0, pkt_cnt=0; the next packet starts cleanly.
- UDP_FIFO_RD_CSUM_EN: payload 8'h45,00,00,1C → csum=16'hBAE3 with csum_vld one cycle on the last handshake.
